score_sequencer: RTL
====================

Name: score_sequencer

Overview:
- Playback controller for a stored score. Steps a note-position index through an array of ARRAY_SIZE entries and holds each note for its stored duration, measured in tempo beats.
- Sits between the user controls (play/stop/pause/loop) and the score memory. Drives the read address and consumes that entry's duration on the next cycle.
- Tells downstream note/audio logic when a new note begins and when playback ends.

Parameters:
- POS_BITS, 8, width of the position index.
- ARRAY_SIZE, 256, number of score entries; last valid index is ARRAY_SIZE-1.
- DUR_BITS, 8, width of the per-note duration in beats.
- DIV_BITS, 20, width of the tempo divider (clocks per beat).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- play  in  1  start pulse; ignored unless in IDLE.
- stop  in  1  abort pulse; highest priority.
- pause  in  1  level; freezes beat counting while high.
- loop_en  in  1  level; sampled at end of score.
- tick_div  in  DIV_BITS  clocks per beat; 0 treated as 1.
- note_dur  in  DUR_BITS  duration of entry at pos; valid one cycle after pos changes.
- pos  out  POS_BITS  score read address.
- note_start  out  1  one-cycle pulse in each LOAD cycle.
- playing  out  1  high in LOAD or HOLD.
- done  out  1  one-cycle pulse on natural end without loop.

Behaviour:
- Reset (rst low, async) forces: state=IDLE, pos=0, remaining=0, divider=0, note_start=0, playing=0, done=0.
- States: IDLE, LOAD, HOLD, DONE.
- IDLE
  - pos held at 0.
  - play=1 and stop=0 → LOAD next cycle.
- LOAD (exactly 1 cycle)
  - note_start=1.
  - If note_dur==0 (end marker): perform end handling.
  - Otherwise: remaining<=note_dur, divider<=0, go to HOLD.
- HOLD
  - pause=0: divider counts 0..eff_div-1, where eff_div=max(tick_div,1). A beat occurs in the cycle divider==eff_div-1; the divider then wraps to 0.
  - pause=1: divider and remaining both frozen.
  - On a beat with remaining>1: remaining decrements.
  - On a beat with remaining==1 and pos!=ARRAY_SIZE-1: pos<=pos+1, go to LOAD.
  - On a beat with remaining==1 and pos==ARRAY_SIZE-1: perform end handling.
- End handling
  - loop_en=1: pos<=0, go to LOAD.
  - loop_en=0: pos<=0, go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- stop=1 in any state → IDLE next cycle with pos=0 and no done pulse. stop wins over play, over a beat and over end handling in the same cycle.
- play outside IDLE: no effect (no restart).
- Timing
  - play sampled at cycle N → LOAD at N+1 with pos=0.
  - One note occupies 1 + note_dur*eff_div cycles with no pause.
- Width rules
  - pos never exceeds ARRAY_SIZE-1; wrap happens only through end handling.
  - remaining and divider never underflow.
  - tick_div is sampled every cycle; a change mid-note applies from the next divider compare. If the divider is already ≥ the new eff_div-1, a beat occurs in the next HOLD cycle.
- Reset mid-note: immediate return to reset values, no done pulse.

Decomposition:
- Shared package score_pkg holds:
  - state enum (IDLE, LOAD, HOLD, DONE);
  - constant END_MARKER_DUR = 0;
  - default ARRAY_SIZE / DUR_BITS / DIV_BITS constants.
- One sub-module, score_beat_gen: the tempo divider.
  - Inputs: clk, rst, enable, clear, tick_div.
  - Output: beat pulse.
  - Uses the same async active-low reset.
- The FSM, remaining counter and pos register live in score_sequencer.

Test Plan:
- Basic timing: reset, tick_div=1, durations {3,1,2}, ARRAY_SIZE=3, loop_en=0, play at cycle 0.
  - note_start at cycles 1, 5, 7.
  - pos sequence 0,1,2.
  - done pulse at cycle 10; IDLE with pos=0 at cycle 11.
- Loop: same score, loop_en=1 → after pos=2 finishes, pos=0 and note_start at cycle 10; playing stays 1 throughout.
- Pause: tick_div=4, note_dur=2, pause high for 10 cycles mid-HOLD → note length extends from 9 to 19 cycles; remaining and divider values are unchanged across the pause.
- End marker and divider-zero: durations {2,0}, tick_div=0 → entry 1 acts as end; done 1 cycle after its LOAD; beats occur every cycle.
- Stop priority: stop asserted in the same cycle as a beat with remaining==1 → IDLE next cycle, pos=0, no note_start, no done. play and stop together in IDLE → stays IDLE.
- Async reset: drop rst mid-HOLD between clock edges → all outputs 0 immediately. After release, play restarts from pos=0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score playback controller.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // A stored duration of zero marks the end of the score.
  localparam int END_MARKER_DUR = 0;

  localparam int DEF_ARRAY_SIZE = 256;
  localparam int DEF_POS_BITS   = 8;
  localparam int DEF_DUR_BITS   = 8;
  localparam int DEF_DIV_BITS   = 20;

endpackage

// File: rtl/score_beat_gen.sv
// Tempo divider: produces one beat pulse every max(tick_div,1) enabled clocks.
module score_beat_gen
  import score_pkg::*;
#(
  parameter int DIV_BITS = DEF_DIV_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                clear,
  input  logic [DIV_BITS-1:0] tick_div,
  output logic                beat
);

  logic [DIV_BITS-1:0] r_div;
  logic [DIV_BITS-1:0] w_last;

  // Terminal count; a zero divider behaves like one (beat every cycle).
  always_comb begin
    w_last = '0;
    if (tick_div != '0) w_last = tick_div - DIV_BITS'(1);
  end

  // Greater-or-equal so that shrinking tick_div mid-note beats immediately.
  assign beat = enable && !clear && (r_div >= w_last);

  // Divider count: cleared outside HOLD, frozen while paused, wraps on a beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (clear) begin
      r_div <= '0;
    end else if (enable) begin
      r_div <= beat ? '0 : r_div + DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Score playback controller: steps pos through the score, holding each note
// for its duration in tempo beats, with play/stop/pause/loop control.
module score_sequencer
  import score_pkg::*;
#(
  parameter int POS_BITS   = DEF_POS_BITS,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DUR_BITS   = DEF_DUR_BITS,
  parameter int DIV_BITS   = DEF_DIV_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play,
  input  logic                stop,
  input  logic                pause,
  input  logic                loop_en,
  input  logic [DIV_BITS-1:0] tick_div,
  input  logic [DUR_BITS-1:0] note_dur,
  output logic [POS_BITS-1:0] pos,
  output logic                note_start,
  output logic                playing,
  output logic                done
);

  localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(ARRAY_SIZE - 1);

  state_t              r_state, w_state_n;
  logic [POS_BITS-1:0] r_pos, w_pos_n;
  logic [DUR_BITS-1:0] r_rem, w_rem_n;
  logic                w_beat;
  logic                w_div_en;
  logic                w_div_clr;

  assign w_div_en  = (r_state == HOLD) && !pause;
  assign w_div_clr = (r_state != HOLD);

  score_beat_gen #(
    .DIV_BITS (DIV_BITS)
  ) u_beat (
    .clk      (clk),
    .rst      (rst),
    .enable   (w_div_en),
    .clear    (w_div_clr),
    .tick_div (tick_div),
    .beat     (w_beat)
  );

  // Next-state, position and remaining-beat logic; stop overrides everything.
  always_comb begin
    w_state_n = r_state;
    w_pos_n   = r_pos;
    w_rem_n   = r_rem;
    case (r_state)
      IDLE: begin
        w_pos_n = '0;
        if (play) w_state_n = LOAD;
      end
      LOAD: begin
        if (note_dur == DUR_BITS'(END_MARKER_DUR)) begin
          w_pos_n   = '0;
          w_state_n = loop_en ? LOAD : DONE;
        end else begin
          w_rem_n   = note_dur;
          w_state_n = HOLD;
        end
      end
      HOLD: begin
        if (w_beat) begin
          if (r_rem > DUR_BITS'(1)) begin
            w_rem_n = r_rem - DUR_BITS'(1);
          end else if (r_pos != LAST_POS) begin
            w_pos_n   = r_pos + POS_BITS'(1);
            w_state_n = LOAD;
          end else begin
            w_pos_n   = '0;
            w_state_n = loop_en ? LOAD : DONE;
          end
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
        w_pos_n   = '0;
      end
    endcase
    if (stop) begin
      w_state_n = IDLE;
      w_pos_n   = '0;
      w_rem_n   = '0;
    end
  end

  // State, position and remaining-beat registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_n;
      r_pos   <= w_pos_n;
      r_rem   <= w_rem_n;
    end
  end

  assign pos        = r_pos;
  assign note_start = (r_state == LOAD);
  assign playing    = (r_state == LOAD) || (r_state == HOLD);
  assign done       = (r_state == DONE);

endmodule
